// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow beats into one wide word.
// Ports: clk_i/rst_i; in_* narrow valid/ready stream; out_* wide stream + beat count.
module stream_upsizer #(
  parameter int WIDTH   = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_last_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [RATIO*WIDTH-1:0]     out_data_o,
  output logic [$clog2(RATIO+1)-1:0] out_beats_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int CW = $clog2(RATIO+1);
  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(RATIO-1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'((TIMEOUT > 0) ? TIMEOUT-1 : 0);
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam bit ONE_LANE = (RATIO == 1);

  typedef enum logic {
    S_FILL,
    S_HOLD
  } state_t;

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic [IW-1:0]            r_idle;
  logic [RATIO*WIDTH-1:0]   r_acc;
  logic [CW-1:0]            r_beats;
  logic                     r_last;
  logic                     r_valid;

  logic w_close;
  logic w_tout;

  assign in_ready_o  = (r_state == S_FILL) ? 1'b1 : out_ready_i;
  assign out_data_o  = r_acc;
  assign out_beats_o = r_beats;
  assign out_last_o  = r_last;
  assign out_valid_o = r_valid;

  assign w_close = in_last_i || (r_cnt == LAST_LANE);
  assign w_tout  = TO_EN && (r_idle == IDLE_MAX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
      r_idle  <= '0;
      r_acc   <= '0;
      r_beats <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (in_valid_i) begin
            for (int k = 0; k < RATIO; k++) begin
              if (r_cnt == CW'(k))
                r_acc[k*WIDTH +: WIDTH] <= in_data_i;
            end
            r_idle <= '0;
            if (w_close) begin
              r_state <= S_HOLD;
              r_valid <= 1'b1;
              r_beats <= r_cnt + CW'(1);
              r_last  <= in_last_i;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (r_cnt == '0) begin
            r_idle <= '0;
          end else if (w_tout) begin
            // idle flush of a partial word
            r_state <= S_HOLD;
            r_valid <= 1'b1;
            r_beats <= r_cnt;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_idle  <= '0;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready_i) begin
            r_idle <= '0;
            if (in_valid_i) begin
              // new beat lands in lane 0 of a cleared word
              r_acc <= (RATIO*WIDTH)'(in_data_i);
              if (ONE_LANE || in_last_i) begin
                r_beats <= CW'(1);
                r_last  <= in_last_i;
                r_cnt   <= '0;
              end else begin
                r_state <= S_FILL;
                r_valid <= 1'b0;
                r_beats <= '0;
                r_last  <= 1'b0;
                r_cnt   <= CW'(1);
              end
            end else begin
              r_state <= S_FILL;
              r_valid <= 1'b0;
              r_acc   <= '0;
              r_beats <= '0;
              r_last  <= 1'b0;
              r_cnt   <= '0;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  a_in_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    in_valid_i && !in_ready_o |=>
      !in_valid_i || ($stable(in_data_i) && $stable(in_last_i))
  );

endmodule
